rcm_cmd_reader: RTL and testbench
=================================

// Module: rcm_cmd_reader
// PURPOSE
//  Read side of the real-time command memory (256 x 338 bit, 1-cycle read latency).
//  - Cyclically scans all rows and finds a command whose TIME_START falls inside the
//    look-ahead window (TIME, TIME+TIME_REZERV].
//  - Presents that command's fields to the sync/execution block with a valid/ready handshake.
//  - After acceptance, asks the write side to clear the row.
//  - Rows whose start time has already passed are flagged stale and are also cleared.
// PARAMETERS
//  N_IDX        255   last row index (rows 0..N_IDX)
//  TIME_REZERV  384   look-ahead window in CLK ticks (8 us at 48 MHz)
//  AW           8     row address width
//  DW           338   row width
// PORTS
//  CLK            in   1   clock
//  rst_n          in   1   async active-low reset
//  EN             in   1   scan enable; 0 = finish current state, then hold in IDLE
//  TIME           in   64  current system time, ticks
//  rd_addr        out  AW  memory read address
//  rden           out  1   memory read enable
//  mem_q          in   DW  memory data: {TSTART[63:0],FREQ[47:0],FSTEP[47:0],FRATE[31:0],
//                          NIMP[15:0],TYPE[1:0],Ti[31:0],Tp[31:0],Tb1[31:0],Tb2[31:0]}
//  cmd_valid      out  1   command fields valid
//  cmd_ready      in   1   executor accepts the command
//  TIME_START_z   out  64  latched command fields (same widths as the packing above)
//  FREQ_z, FREQ_STEP_z, FREQ_RATE_z, N_impuls_z, TYPE_impulse_z,
//  Interval_Ti_z, Interval_Tp_z, Tblank1_z, Tblank2_z
//                 out  ..
//  clr_req        out  1   request to clear row clr_addr
//  clr_addr       out  AW  row to clear
//  clr_ack        in   1   write side has cleared the row (1-cycle pulse)
//  stale_cnt      out  16  count of rows dropped because they were overdue; saturates at FFFF
//  scan_wrap      out  1   1-cycle pulse when the scan wraps from N_IDX to 0
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, scan pointer 0.
//  Empty row: TSTART == 64'hFFFF_FFFF_FFFF_FFFF.
//  FSM:
//  - IDLE:  when EN=1, go to RD.
//  - RD:    rden=1, rd_addr=ptr; go to WAIT.
//  - WAIT:  rden=0; mem_q becomes valid at the end of this cycle; go to CHECK.
//  - CHECK: evaluate the row using T = TIME sampled in CHECK.
//    - Empty: advance ptr.
//    - T < TSTART <= T+TIME_REZERV: latch all fields, capture clr_addr=ptr, go to ISSUE.
//    - TSTART <= T: stale_cnt++, clr_addr=ptr, go to CLR.
//    - Any other row: advance ptr.
//  - Advance ptr: ptr = (ptr==N_IDX) ? 0 : ptr+1, with scan_wrap pulsed on wrap.
//    Then go to RD if EN=1, else IDLE.
//  - ISSUE: cmd_valid=1 and the fields are held stable until cmd_valid&&cmd_ready;
//    then go to CLR. cmd_valid deasserts the cycle after the handshake.
//    EN=0 does not abort ISSUE.
//  - CLR: clr_req=1 and clr_addr held until clr_ack. On clr_ack, clr_req deasserts
//    next cycle and the FSM advances ptr. clr_ack outside CLR is ignored.
//  Latency: from EN rising to first rden is 1 cycle. One row takes 3 cycles (RD, WAIT, CHECK),
//    so a full 256-row scan is 768 cycles, which exceeds TIME_REZERV. The window is therefore
//    treated as best-effort; late commands are caught as stale.
//  Width rules: T+TIME_REZERV is computed in 65 bits, so a window near 2^64 does not wrap.
//    Comparisons are unsigned 64-bit.
//  Ordering: one command is in flight at a time. Among rows due in the same pass, the lowest
//    address after ptr is issued first.
//  Fields (_z outputs) keep their last value after the handshake. They are updated only in CHECK.
//  rst_n asserted mid-ISSUE/CLR: immediate return to reset values. A pending clr_req is dropped,
//    and the row is re-evaluated on the next scan.
// TESTING
//  1. Reset, memory all-empty, EN=1: rden pulses every 3 cycles, cmd_valid stays 0, scan_wrap
//     fires once per 768 cycles.
//  2. Row 5: TSTART=1000, TIME=700 in CHECK: cmd_valid=1 with FREQ_z etc equal to row 5.
//     cmd_ready held 0 for 10 cycles -> fields stable. Handshake -> clr_req with clr_addr=5
//     -> clr_ack -> scan resumes at row 6.
//  3. Row 9: TSTART=500, TIME=600: no cmd_valid, stale_cnt 0->1, clr_req with clr_addr=9.
//  4. Row 3: TSTART=TIME+385 (outside window): skipped. Same row with TIME advanced by 2 on a
//     later pass: issued.
//  5. Row N_IDX due: clr_addr=255, and the next rd_addr after clr_ack is 0 with scan_wrap=1.
//  6. rst_n low during ISSUE: cmd_valid/clr_req 0 asynchronously. After release the row is
//     found again and reissued.

Source files
------------

// File: rtl/rcm_cmd_reader.sv
// rcm_cmd_reader: read side of the real-time command memory.
// Scans rows cyclically and issues the first command whose start time falls
// inside the look-ahead window (TIME, TIME+TIME_REZERV]. Overdue rows are
// counted as stale. Both issued rows and stale rows are handed to the write
// side for clearing.
//
// Handshake: cmd_valid rises with the latched fields and stays high, with the
// fields stable, until a cycle where cmd_valid && cmd_ready are both 1. The
// command transfers on that edge, and cmd_valid is low the next cycle.
// clr_req follows the same rule against clr_ack: it is held until clr_ack is
// seen, and clr_ack is ignored outside the clear state.
module rcm_cmd_reader #(
    parameter int N_IDX       = 255,
    parameter int TIME_REZERV = 384,
    parameter int AW          = 8,
    parameter int DW          = 338
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic          EN,
    input  logic [63:0]   TIME,
    output logic [AW-1:0] rd_addr,
    output logic          rden,
    input  logic [DW-1:0] mem_q,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [63:0]   TIME_START_z,
    output logic [47:0]   FREQ_z,
    output logic [47:0]   FREQ_STEP_z,
    output logic [31:0]   FREQ_RATE_z,
    output logic [15:0]   N_impuls_z,
    output logic [1:0]    TYPE_impulse_z,
    output logic [31:0]   Interval_Ti_z,
    output logic [31:0]   Interval_Tp_z,
    output logic [31:0]   Tblank1_z,
    output logic [31:0]   Tblank2_z,
    output logic          clr_req,
    output logic [AW-1:0] clr_addr,
    input  logic          clr_ack,
    output logic [15:0]   stale_cnt,
    output logic          scan_wrap,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_ISSUE = 3'd4,
        S_CLR   = 3'd5
    } state_t;

    localparam logic [63:0] EMPTY_TS = 64'hFFFF_FFFF_FFFF_FFFF;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] fld_q, fld_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic [15:0]   stale_q, stale_d;
    logic          wrap_q, wrap_d;

    logic [63:0]   row_ts;
    logic [64:0]   win_end;
    logic          advance;

    // Start time of the row under check; window end kept 65 bits wide so it cannot wrap
    assign row_ts  = mem_q[DW-1 -: 64];
    assign win_end = {1'b0, TIME} + 65'(TIME_REZERV);

    // State, scan pointer, latched fields and counters
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            fld_q      <= '0;
            clr_addr_q <= '0;
            stale_q    <= '0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            fld_q      <= fld_d;
            clr_addr_q <= clr_addr_d;
            stale_q    <= stale_d;
            wrap_q     <= wrap_d;
        end
    end

    // Next-state logic: row evaluation, handshakes and pointer advance
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        fld_d      = fld_q;
        clr_addr_d = clr_addr_q;
        stale_d    = stale_q;
        wrap_d     = 1'b0;
        advance    = 1'b0;

        case (state_q)
            S_IDLE:  if (EN) state_d = S_RD;
            S_RD:    state_d = S_WAIT;
            S_WAIT:  state_d = S_CHECK;
            S_CHECK: begin
                if (row_ts == EMPTY_TS) begin
                    advance = 1'b1;
                end else if (row_ts > TIME && {1'b0, row_ts} <= win_end) begin
                    fld_d      = mem_q;
                    clr_addr_d = ptr_q;
                    state_d    = S_ISSUE;
                end else if (row_ts <= TIME) begin
                    if (stale_q != 16'hFFFF) stale_d = stale_q + 16'd1;
                    clr_addr_d = ptr_q;
                    state_d    = S_CLR;
                end else begin
                    advance = 1'b1;
                end
            end
            S_ISSUE: if (cmd_ready) state_d = S_CLR;
            S_CLR:   if (clr_ack) advance = 1'b1;
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (ptr_q == AW'(N_IDX)) begin
                ptr_d  = '0;
                wrap_d = 1'b1;
            end else begin
                ptr_d  = ptr_q + AW'(1);
            end
            state_d = EN ? S_RD : S_IDLE;
        end
    end

    assign rden      = (state_q == S_RD);
    assign rd_addr   = ptr_q;
    assign cmd_valid = (state_q == S_ISSUE);
    assign clr_req   = (state_q == S_CLR);
    assign clr_addr  = clr_addr_q;
    assign stale_cnt = stale_q;
    assign scan_wrap = wrap_q;
    assign dbg_state = state_q;

    assign TIME_START_z   = fld_q[337:274];
    assign FREQ_z         = fld_q[273:226];
    assign FREQ_STEP_z    = fld_q[225:178];
    assign FREQ_RATE_z    = fld_q[177:146];
    assign N_impuls_z     = fld_q[145:130];
    assign TYPE_impulse_z = fld_q[129:128];
    assign Interval_Ti_z  = fld_q[127:96];
    assign Interval_Tp_z  = fld_q[95:64];
    assign Tblank1_z      = fld_q[63:32];
    assign Tblank2_z      = fld_q[31:0];

endmodule

// File: tb/tb_rcm_cmd_reader.sv
// Directed bench for rcm_cmd_reader with a behavioural 256-row memory.
module tb_rcm_cmd_reader;

  localparam logic [63:0] EMPTY = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         CLK;
  logic         rst_n;
  logic         EN;
  logic [63:0]  TIME;
  logic [7:0]   rd_addr;
  logic         rden;
  logic [337:0] mem_q;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [63:0]  TIME_START_z;
  logic [47:0]  FREQ_z;
  logic [47:0]  FREQ_STEP_z;
  logic [31:0]  FREQ_RATE_z;
  logic [15:0]  N_impuls_z;
  logic [1:0]   TYPE_impulse_z;
  logic [31:0]  Interval_Ti_z;
  logic [31:0]  Interval_Tp_z;
  logic [31:0]  Tblank1_z;
  logic [31:0]  Tblank2_z;
  logic         clr_req;
  logic [7:0]   clr_addr;
  logic         clr_ack;
  logic [15:0]  stale_cnt;
  logic         scan_wrap;
  logic [2:0]   dbg_state;

  logic [337:0] mem [256];

  int n_vec = 0;
  int n_err = 0;

  rcm_cmd_reader dut (
    .CLK(CLK), .rst_n(rst_n), .EN(EN), .TIME(TIME),
    .rd_addr(rd_addr), .rden(rden), .mem_q(mem_q),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .TIME_START_z(TIME_START_z), .FREQ_z(FREQ_z), .FREQ_STEP_z(FREQ_STEP_z),
    .FREQ_RATE_z(FREQ_RATE_z), .N_impuls_z(N_impuls_z), .TYPE_impulse_z(TYPE_impulse_z),
    .Interval_Ti_z(Interval_Ti_z), .Interval_Tp_z(Interval_Tp_z),
    .Tblank1_z(Tblank1_z), .Tblank2_z(Tblank2_z),
    .clr_req(clr_req), .clr_addr(clr_addr), .clr_ack(clr_ack),
    .stale_cnt(stale_cnt), .scan_wrap(scan_wrap), .dbg_state(dbg_state)
  );

  // clock / memory model
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) if (rden) mem_q <= mem[rd_addr];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // helpers
  function automatic logic [337:0] mk_row(input logic [63:0] ts, input logic [7:0] s);
    return {ts, {40'hF0F0_1234_56, s}, {40'h0A0B_0C0D_0E, s}, {24'h13_5791, s},
            {8'h5A, s}, s[1:0], {24'hAAAA_AA, s}, {24'hBBBB_BB, s},
            {24'hCCCC_CC, s}, {24'hDDDD_DD, s}};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_fields(input string tag, input logic [63:0] ts, input logic [7:0] s);
    chk({tag, "_tstart"}, TIME_START_z, ts);
    chk({tag, "_freq"},   64'(FREQ_z),         64'({40'hF0F0_1234_56, s}));
    chk({tag, "_fstep"},  64'(FREQ_STEP_z),    64'({40'h0A0B_0C0D_0E, s}));
    chk({tag, "_frate"},  64'(FREQ_RATE_z),    64'({24'h13_5791, s}));
    chk({tag, "_nimp"},   64'(N_impuls_z),     64'({8'h5A, s}));
    chk({tag, "_type"},   64'(TYPE_impulse_z), 64'(s[1:0]));
    chk({tag, "_ti"},     64'(Interval_Ti_z),  64'({24'hAAAA_AA, s}));
    chk({tag, "_tp"},     64'(Interval_Tp_z),  64'({24'hBBBB_BB, s}));
    chk({tag, "_tb1"},    64'(Tblank1_z),      64'({24'hCCCC_CC, s}));
    chk({tag, "_tb2"},    64'(Tblank2_z),      64'({24'hDDDD_DD, s}));
  endtask

  // hold reset, empty the memory, release on a falling edge with EN=0
  task automatic reset_dut();
    rst_n = 1'b0; EN = 1'b0; cmd_ready = 1'b0; clr_ack = 1'b0; TIME = 64'd0;
    for (int i = 0; i < 256; i++) mem[i] = {EMPTY, 274'd0};
    @(negedge CLK); @(negedge CLK);
    rst_n = 1'b1;
  endtask

  // mode 0: stop on cmd_valid, 1: stop on clr_req, 2: run the full budget
  task automatic run_until(input int mode, input int budget,
                           output bit hit, output bit saw_v, output bit saw_c);
    hit = 1'b0; saw_v = 1'b0; saw_c = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge CLK);
      if (cmd_valid === 1'b1) saw_v = 1'b1;
      if (clr_req === 1'b1) saw_c = 1'b1;
      if (mode == 0 && cmd_valid === 1'b1) begin hit = 1'b1; break; end
      if (mode == 1 && clr_req === 1'b1) begin hit = 1'b1; break; end
    end
  endtask

  // called at a falling edge with clr_req high: ack one cycle, expect the next read
  task automatic clear_row(input string tag, input logic [7:0] addr, input logic [7:0] next_addr);
    chk({tag, "_clr_addr"}, 64'(clr_addr), 64'(addr));
    clr_ack = 1'b1;
    mem[addr] = {EMPTY, 274'd0};
    @(negedge CLK);
    clr_ack = 1'b0;
    chk({tag, "_clr_drop"}, 64'(clr_req), 64'd0);
    chk({tag, "_next_rden"}, 64'(rden), 64'd1);
    chk({tag, "_next_addr"}, 64'(rd_addr), 64'(next_addr));
  endtask

  // called at a falling edge with cmd_valid high
  task automatic accept_cmd(input string tag, input logic [7:0] addr, input logic [7:0] next_addr);
    cmd_ready = 1'b1;
    @(negedge CLK);
    cmd_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(cmd_valid), 64'd0);
    chk({tag, "_clr_req"}, 64'(clr_req), 64'd1);
    clear_row(tag, addr, next_addr);
  endtask

  // directed sequence
  initial begin
    bit hit, saw_v, saw_c;
    int n_rden, n_wrap;
    bit v_seen;
    logic [47:0] freq_ref;

    // 1: reset values, empty memory scan rhythm
    reset_dut();
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_clr_req",   64'(clr_req),   64'd0);
    chk("rst_rden",      64'(rden),      64'd0);
    chk("rst_rd_addr",   64'(rd_addr),   64'd0);
    chk("rst_stale",     64'(stale_cnt), 64'd0);
    chk("rst_wrap",      64'(scan_wrap), 64'd0);
    chk("rst_freq",      64'(FREQ_z),    64'd0);
    chk("rst_clr_addr",  64'(clr_addr),  64'd0);
    EN = 1'b1;
    @(negedge CLK);
    chk("en_latency_rden", 64'(rden), 64'd1);
    chk("en_latency_addr", 64'(rd_addr), 64'd0);
    n_rden = 0; n_wrap = 0; v_seen = 1'b0;
    for (int i = 1; i <= 768; i++) begin
      @(negedge CLK);
      if (rden === 1'b1) n_rden++;
      if (scan_wrap === 1'b1) n_wrap++;
      if (cmd_valid !== 1'b0) v_seen = 1'b1;
    end
    chk("empty_rden_count", 64'(n_rden), 64'd256);
    chk("empty_wrap_count", 64'(n_wrap), 64'd1);
    chk("empty_no_valid",   64'(v_seen), 64'd0);
    chk("empty_wrap_addr",  64'(rd_addr), 64'd0);

    // 2: row 5 in window, back-pressure then handshake
    reset_dut();
    TIME = 64'd700;
    mem[5] = mk_row(64'd1000, 8'h55);
    EN = 1'b1;
    run_until(0, 100, hit, saw_v, saw_c);
    chk("r5_found", 64'(hit), 64'd1);
    check_fields("r5", 64'd1000, 8'h55);
    freq_ref = FREQ_z;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      TIME = TIME + 64'd1;
      chk("r5_hold_valid", 64'(cmd_valid), 64'd1);
      chk("r5_hold_freq", 64'(FREQ_z), 64'(freq_ref));
    end
    accept_cmd("r5", 8'd5, 8'd6);
    check_fields("r5_after", 64'd1000, 8'h55);

    // 3: row 9 overdue -> stale, cleared, never issued
    reset_dut();
    TIME = 64'd600;
    mem[9] = mk_row(64'd500, 8'h99);
    EN = 1'b1;
    run_until(1, 100, hit, saw_v, saw_c);
    chk("r9_clr_found", 64'(hit), 64'd1);
    chk("r9_no_valid", 64'(saw_v), 64'd0);
    chk("r9_stale", 64'(stale_cnt), 64'd1);
    clear_row("r9", 8'd9, 8'd10);
    chk("r9_stale_after", 64'(stale_cnt), 64'd1);

    // 4: row 3 just outside the window, then inside after TIME += 2
    reset_dut();
    TIME = 64'd1000;
    mem[3] = mk_row(64'd1385, 8'h33);
    EN = 1'b1;
    run_until(2, 800, hit, saw_v, saw_c);
    chk("r3_out_no_valid", 64'(saw_v), 64'd0);
    chk("r3_out_no_clr", 64'(saw_c), 64'd0);
    TIME = 64'd1002;
    run_until(0, 800, hit, saw_v, saw_c);
    chk("r3_in_found", 64'(hit), 64'd1);
    check_fields("r3", 64'd1385, 8'h33);
    accept_cmd("r3", 8'd3, 8'd4);

    // 65-bit window end: TIME near 2^64 must still catch the row
    reset_dut();
    TIME = 64'hFFFF_FFFF_FFFF_FFF0;
    mem[7] = mk_row(64'hFFFF_FFFF_FFFF_FFFE, 8'h77);
    EN = 1'b1;
    run_until(0, 100, hit, saw_v, saw_c);
    chk("top_found", 64'(hit), 64'd1);
    chk("top_tstart", TIME_START_z, 64'hFFFF_FFFF_FFFF_FFFE);
    accept_cmd("top", 8'd7, 8'd8);

    // 5: last row due, scan wraps to 0 after the clear
    reset_dut();
    TIME = 64'd2000;
    mem[255] = mk_row(64'd2100, 8'hEE);
    EN = 1'b1;
    run_until(0, 1000, hit, saw_v, saw_c);
    chk("r255_found", 64'(hit), 64'd1);
    check_fields("r255", 64'd2100, 8'hEE);
    accept_cmd("r255", 8'd255, 8'd0);
    chk("r255_wrap", 64'(scan_wrap), 64'd1);

    // 6: reset mid-issue drops the command; row is found again afterwards
    reset_dut();
    TIME = 64'd5000;
    mem[5] = mk_row(64'd5200, 8'h66);
    EN = 1'b1;
    run_until(0, 100, hit, saw_v, saw_c);
    chk("rsti_found", 64'(hit), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rsti_valid_low", 64'(cmd_valid), 64'd0);
    chk("rsti_clr_low", 64'(clr_req), 64'd0);
    chk("rsti_freq_zero", 64'(FREQ_z), 64'd0);
    @(negedge CLK);
    rst_n = 1'b1;
    run_until(0, 100, hit, saw_v, saw_c);
    chk("rsti_refound", 64'(hit), 64'd1);
    check_fields("rsti", 64'd5200, 8'h66);
    accept_cmd("rsti", 8'd5, 8'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
